car_sensor_conditioner: RTL

// Conditions the raw farm-road vehicle-loop sensor into the clean car-request level (C) consumed by the

---
 rtl/car_sensor_conditioner_pkg.sv | 15 +
 rtl/car_sensor_conditioner_if.sv | 31 +++
 rtl/car_sensor_conditioner_sig_debounce.sv | 53 +++++
 rtl/car_sensor_conditioner.sv | 94 +++++++++
 4 files changed

// File: rtl/car_sensor_conditioner_pkg.sv
// Shared definitions for the farm-road car sensor conditioner and its controller.
package car_sensor_conditioner_pkg;

    // Request FSM encoding; 2'b11 is unused and recovers to idle.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StReq   = 2'b01,
        StServe = 2'b10
    } req_state_e;

    localparam int unsigned DebCyclesDefault   = 4;
    localparam int unsigned StuckCyclesDefault = 255;
    localparam int unsigned CntWDefault        = 4;

endpackage

// File: rtl/car_sensor_conditioner_if.sv
// Sensor/controller-facing signal bundle of the car sensor conditioner.
interface car_sensor_conditioner_if #(
    parameter int unsigned CNT_W = 4
);
    logic             sensor_raw;
    logic             fg_in;
    logic             car_req;
    logic             car_present;
    logic [CNT_W-1:0] car_count;
    logic             stuck_err;

    // master: the side driving the sensor and farm-road green.
    modport master (
        output sensor_raw,
        output fg_in,
        input  car_req,
        input  car_present,
        input  car_count,
        input  stuck_err
    );

    // slave: the conditioner itself.
    modport slave (
        input  sensor_raw,
        input  fg_in,
        output car_req,
        output car_present,
        output car_count,
        output stuck_err
    );
endinterface

// File: rtl/car_sensor_conditioner_sig_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; emits level and rise pulse.
module car_sensor_conditioner_sig_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
    localparam logic [CntW-1:0] DebLast = CntW'(DEB_CYCLES - 1);

    logic            sync1_q, sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;

    // Accept a level change only after DEB_CYCLES consecutive differing synced samples.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == DebLast) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync_q  <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
endmodule

// File: rtl/car_sensor_conditioner.sv
// Conditions the raw farm-road loop sensor into the controller's car request, with a waiting-car
// counter and a sticky stuck-sensor flag.
module car_sensor_conditioner
    import car_sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DebCyclesDefault,
    parameter int unsigned CNT_W        = CntWDefault,
    parameter int unsigned STUCK_CYCLES = StuckCyclesDefault
) (
    input logic                    clk,
    input logic                    rst,
    car_sensor_conditioner_if.slave bus
);
    localparam int unsigned StuckW = $clog2(STUCK_CYCLES + 1);
    localparam logic [StuckW-1:0] StuckLast = StuckW'(STUCK_CYCLES - 1);

    logic present, arrival;

    req_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [StuckW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic              stuck_err_q, stuck_err_d;
    logic              serve_entry;
    logic              stuck_hold;

    car_sensor_conditioner_sig_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.sensor_raw),
        .level (present),
        .rise  (arrival)
    );

    // Request FSM next state; car_req is registered from the next state.
    always_comb begin
        state_d     = state_q;
        serve_entry = 1'b0;
        case (state_q)
            StIdle:  if (arrival) state_d = StReq;
            StReq: begin
                if (bus.fg_in) begin
                    state_d     = StServe;
                    serve_entry = 1'b1;
                end
            end
            StServe: if (!bus.fg_in) state_d = present ? StReq : StIdle;
            default: state_d = StIdle;
        endcase
        req_d = (state_d == StReq);
    end

    // Waiting-car counter and stuck timer next state.
    always_comb begin
        count_d = count_q;
        if (serve_entry) begin
            // Clear on service wins, but an arrival on the same edge still counts.
            count_d = arrival ? CNT_W'(1) : '0;
        end else if (arrival && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end

        stuck_hold  = present && !bus.fg_in;
        stuck_cnt_d = '0;
        if (stuck_hold) begin
            stuck_cnt_d = (stuck_cnt_q == '1) ? stuck_cnt_q : stuck_cnt_q + 1'b1;
        end
        stuck_err_d = stuck_err_q || (stuck_hold && (stuck_cnt_q == StuckLast));
    end

    // Registered FSM, counters and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            count_q     <= '0;
            stuck_cnt_q <= '0;
            stuck_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            count_q     <= count_d;
            stuck_cnt_q <= stuck_cnt_d;
            stuck_err_q <= stuck_err_d;
        end
    end

    assign bus.car_req     = req_q;
    assign bus.car_present = present;
    assign bus.car_count   = count_q;
    assign bus.stuck_err   = stuck_err_q;
endmodule
